// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: FSM state and the queued command record.
package alu_seq_pkg;

    localparam int SEQ_CONTROL_BITS  = 3;
    localparam int SEQ_DATA_WIDTH    = 32;
    localparam int SEQ_ADDRESS_WIDTH = 5;
    localparam int SEQ_FIFO_DEPTH    = 4;
    localparam int SEQ_REP_BITS      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_CONTROL_BITS-1:0]  op;
        logic                         src;
        logic                         wb;
        logic                         stop_on_zero;
        logic [SEQ_ADDRESS_WIDTH-1:0] rs1;
        logic [SEQ_ADDRESS_WIDTH-1:0] rs2;
        logic [SEQ_ADDRESS_WIDTH-1:0] rd;
        logic [SEQ_DATA_WIDTH-1:0]    imm;
        logic [SEQ_REP_BITS-1:0]      repeat_cnt;
    } seq_cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command push channel: producer offers a command, sequencer accepts when ready.
interface alu_cmd_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int CONTROL_BITS  = SEQ_CONTROL_BITS,
    parameter int DATA_WIDTH    = SEQ_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = SEQ_ADDRESS_WIDTH,
    parameter int REP_BITS      = SEQ_REP_BITS
) ();

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [CONTROL_BITS-1:0]  cmd_op;
    logic                     cmd_src;
    logic                     cmd_wb;
    logic                     cmd_stop_on_zero;
    logic [ADDRESS_WIDTH-1:0] cmd_rs1;
    logic [ADDRESS_WIDTH-1:0] cmd_rs2;
    logic [ADDRESS_WIDTH-1:0] cmd_rd;
    logic [DATA_WIDTH-1:0]    cmd_imm;
    logic [REP_BITS-1:0]      cmd_repeat;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_wb, cmd_stop_on_zero,
               cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_wb, cmd_stop_on_zero,
               cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, cmd_repeat,
        output cmd_ready
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO with registered occupancy count; pointers wrap modulo DEPTH.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  logic     i_pop,
    input  seq_cmd_t i_data,
    output seq_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    seq_cmd_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Pops queued ALU commands and drives the regfile/ALU datapath, reissuing each
// command repeat+1 times or until its result is zero when stop_on_zero is set.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CONTROL_BITS  = SEQ_CONTROL_BITS,
    parameter int DATA_WIDTH    = SEQ_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = SEQ_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH    = SEQ_FIFO_DEPTH,
    parameter int REP_BITS      = SEQ_REP_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_cmd_sequencer_if.slave       cmd,
    output logic [CONTROL_BITS-1:0]  ALUControl,
    output logic                     ALUSrc,
    output logic                     RegWrite,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     result_eq_zero,
    output logic                     busy,
    output logic                     cmd_done,
    output logic                     early_stop,
    output logic                     zero_flag
);

    seq_state_e               r_state;
    seq_state_e               w_next_state;
    seq_cmd_t                 w_push_data;
    seq_cmd_t                 w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_complete;
    logic [REP_BITS-1:0]      r_iter_cnt;
    logic                     r_stop;
    logic [CONTROL_BITS-1:0]  r_alu_ctrl;
    logic                     r_alu_src;
    logic                     r_reg_write;
    logic [ADDRESS_WIDTH-1:0] r_rs1;
    logic [ADDRESS_WIDTH-1:0] r_rs2;
    logic [ADDRESS_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]    r_imm;
    logic                     r_done;
    logic                     r_early;
    logic                     r_zero;

    always_comb begin
        w_push_data.op           = cmd.cmd_op;
        w_push_data.src          = cmd.cmd_src;
        w_push_data.wb           = cmd.cmd_wb;
        w_push_data.stop_on_zero = cmd.cmd_stop_on_zero;
        w_push_data.rs1          = cmd.cmd_rs1;
        w_push_data.rs2          = cmd.cmd_rs2;
        w_push_data.rd           = cmd.cmd_rd;
        w_push_data.imm          = cmd.cmd_imm;
        w_push_data.repeat_cnt   = cmd.cmd_repeat;
    end

    alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd.cmd_valid),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Completion and the next pop share one edge so back-to-back commands have no bubble.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_complete = (r_iter_cnt == '0) || (r_stop && result_eq_zero);
                if (w_complete) begin
                    w_pop = !w_empty;
                    if (w_empty) w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iter_cnt  <= '0;
            r_stop      <= 1'b0;
            r_alu_ctrl  <= '0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_done      <= 1'b0;
            r_early     <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (r_state == ST_EXEC) r_zero <= result_eq_zero;
            r_done <= w_complete;
            if (w_complete) r_early <= (r_iter_cnt != '0);
            if (w_pop) begin
                r_alu_ctrl  <= w_head.op;
                r_alu_src   <= w_head.src;
                r_reg_write <= w_head.wb;
                r_stop      <= w_head.stop_on_zero;
                r_rs1       <= w_head.rs1;
                r_rs2       <= w_head.rs2;
                r_rd        <= w_head.rd;
                r_imm       <= w_head.imm;
                r_iter_cnt  <= w_head.repeat_cnt;
            end else if (w_complete) begin
                r_reg_write <= 1'b0;
                r_iter_cnt  <= '0;
            end else if (r_state == ST_EXEC) begin
                r_iter_cnt <= r_iter_cnt - 1'b1;
            end
        end
    end

    assign ALUControl    = r_alu_ctrl;
    assign ALUSrc        = r_alu_src;
    assign RegWrite      = r_reg_write;
    assign rs1           = r_rs1;
    assign rs2           = r_rs2;
    assign rd            = r_rd;
    assign ImmOp         = r_imm;
    assign cmd_done      = r_done;
    assign early_stop    = r_early;
    assign zero_flag     = r_zero;
    assign busy          = (r_state == ST_EXEC) || !w_empty;
    assign cmd.cmd_ready = !w_full;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with an attached regfile/ALU and a queue-based reference model.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int CB    = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int RB    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CB-1:0] ALUControl;
    logic          ALUSrc, RegWrite;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] ImmOp;
    logic          result_eq_zero;
    logic          busy, cmd_done, early_stop, zero_flag;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.CONTROL_BITS(CB), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REP_BITS(RB)) cif ();

    alu_cmd_sequencer #(
        .CONTROL_BITS(CB), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .REP_BITS(RB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cif),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp),
        .result_eq_zero(result_eq_zero),
        .busy(busy), .cmd_done(cmd_done), .early_stop(early_stop), .zero_flag(zero_flag)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu(input logic [CB-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Environment: register file and ALU driven by the DUT outputs.
    logic [DW-1:0] rf [32] = '{default: '0};
    logic [DW-1:0] env_a, env_b, env_res;

    always_comb begin
        env_a          = (rs1 == '0) ? '0 : rf[rs1];
        env_b          = ALUSrc ? ImmOp : ((rs2 == '0) ? '0 : rf[rs2]);
        env_res        = alu(ALUControl, env_a, env_b);
        result_eq_zero = (env_res == '0);
    end

    always @(posedge clk) begin
        if (RegWrite && rd != '0) rf[rd] <= env_res;
    end

    // Reference model: command queue plus the command currently being issued.
    seq_cmd_t      mq[$];
    seq_cmd_t      mcur, e_out, m_new;
    bit            mact = 0, mvalid = 0, m_acc;
    int            mrem = 0;
    logic [DW-1:0] mrf [32] = '{default: '0};
    logic [DW-1:0] m_a, m_b, m_r;
    logic          e_done = 0, e_early = 0, e_zero = 0;

    always @(posedge clk) begin
        m_new.op           = cif.cmd_op;
        m_new.src          = cif.cmd_src;
        m_new.wb           = cif.cmd_wb;
        m_new.stop_on_zero = cif.cmd_stop_on_zero;
        m_new.rs1          = cif.cmd_rs1;
        m_new.rs2          = cif.cmd_rs2;
        m_new.rd           = cif.cmd_rd;
        m_new.imm          = cif.cmd_imm;
        m_new.repeat_cnt   = cif.cmd_repeat;
        m_acc = cif.cmd_valid && (mq.size() < DEPTH);
        if (mact) begin
            m_a = (mcur.rs1 == '0) ? '0 : mrf[mcur.rs1];
            m_b = mcur.src ? mcur.imm : ((mcur.rs2 == '0) ? '0 : mrf[mcur.rs2]);
            m_r = alu(mcur.op, m_a, m_b);
            // the register file is outside the reset domain, so the write still lands
            if (mcur.wb && mcur.rd != '0) mrf[mcur.rd] = m_r;
        end
        if (!rst_n) begin
            mq.delete();
            mact = 0; mrem = 0; e_out = '0;
            e_done = 0; e_early = 0; e_zero = 0;
            mvalid = 1;
        end else begin
            e_done = 0;
            if (mact) begin
                e_zero = (m_r == '0);
                if (mrem == 0 || (mcur.stop_on_zero && m_r == '0)) begin
                    e_done  = 1;
                    e_early = (mrem != 0);
                    if (mq.size() > 0) begin
                        mcur = mq.pop_front(); mrem = int'(mcur.repeat_cnt); e_out = mcur;
                    end else begin
                        mact = 0;
                    end
                end else begin
                    mrem--;
                end
            end else if (mq.size() > 0) begin
                mcur = mq.pop_front(); mrem = int'(mcur.repeat_cnt); e_out = mcur; mact = 1;
            end
            if (m_acc) mq.push_back(m_new);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("RegWrite",   RegWrite,      mact && mcur.wb);
            check("ALUControl", ALUControl,    e_out.op);
            check("ALUSrc",     ALUSrc,        e_out.src);
            check("rs1",        rs1,           e_out.rs1);
            check("rs2",        rs2,           e_out.rs2);
            check("rd",         rd,            e_out.rd);
            check("ImmOp",      ImmOp,         e_out.imm);
            check("cmd_ready",  cif.cmd_ready, mq.size() < DEPTH);
            check("busy",       busy,          mact || mq.size() > 0);
            check("cmd_done",   cmd_done,      e_done);
            check("early_stop", early_stop,    e_early);
            check("zero_flag",  zero_flag,     e_zero);
        end
    end

    // Event counters for the directed scenarios.
    int  wr_cnt = 0, done_cnt = 0, gap_cnt = 0;
    bit  gap_en = 0, saw_not_ready = 0;

    always @(negedge clk) begin
        if (RegWrite) wr_cnt++;
        if (cmd_done) done_cnt++;
        if (gap_en && busy && !RegWrite) gap_cnt++;
    end

    function automatic seq_cmd_t mk(input logic [CB-1:0] op, input logic src, input logic wb, input logic stop,
                                    input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                                    input logic [DW-1:0] imm, input logic [RB-1:0] rep);
        seq_cmd_t c;
        c.op = op; c.src = src; c.wb = wb; c.stop_on_zero = stop;
        c.rs1 = a; c.rs2 = b; c.rd = d; c.imm = imm; c.repeat_cnt = rep;
        return c;
    endfunction

    task automatic drive(input seq_cmd_t c, input logic v);
        cif.cmd_valid        = v;
        cif.cmd_op           = c.op;
        cif.cmd_src          = c.src;
        cif.cmd_wb           = c.wb;
        cif.cmd_stop_on_zero = c.stop_on_zero;
        cif.cmd_rs1          = c.rs1;
        cif.cmd_rs2          = c.rs2;
        cif.cmd_rd           = c.rd;
        cif.cmd_imm          = c.imm;
        cif.cmd_repeat       = c.repeat_cnt;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input seq_cmd_t c);
        logic acc;
        acc = 1'b0;
        drive(c, 1'b1);
        for (int n = 0; n < 200; n++) begin
            acc = cif.cmd_ready;
            if (!acc) saw_not_ready = 1;
            @(negedge clk);
            if (acc) break;
        end
        cif.cmd_valid = 1'b0;
        check("accept", acc, 1'b1);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    int w0, d0;
    logic [DW-1:0] x12_base, x13_base;

    initial begin
        rst_n = 1'b0;
        drive('0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_ImmOp", ImmOp, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cif.cmd_ready, 1'b1);
        check("rst_done", cmd_done, 1'b0);
        check("rst_early", early_stop, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // single add x10 = x0 + 5: writes in the second cycle after acceptance
        w0 = wr_cnt; d0 = done_cnt;
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 32'd5, 4'd0));
        check("s1_lat0_RegWrite", RegWrite, 1'b0);
        @(negedge clk);
        check("s1_lat1_RegWrite", RegWrite, 1'b1);
        check("s1_ImmOp", ImmOp, 32'd5);
        wait_idle(50);
        check("s1_writes", wr_cnt - w0, 1);
        check("s1_done", done_cnt - d0, 1);
        check("s1_a0", rf[10], 32'd5);

        // x10 = 0, then x10 += 1 eight times
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 32'd0, 4'd0));
        wait_idle(50);
        w0 = wr_cnt; d0 = done_cnt;
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd10, 32'd1, 4'd7));
        wait_idle(50);
        check("s2_writes", wr_cnt - w0, 8);
        check("s2_done", done_cnt - d0, 1);
        check("s2_a0", rf[10], 32'd8);
        check("s2_early", early_stop, 1'b0);

        // x10 = 3, then decrement with stop_on_zero
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 32'd3, 4'd0));
        wait_idle(50);
        w0 = wr_cnt;
        send(mk(3'd1, 1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd10, 32'd1, 4'd15));
        wait_idle(50);
        check("s3_writes", wr_cnt - w0, 3);
        check("s3_a0", rf[10], 32'd0);
        check("s3_early", early_stop, 1'b1);
        check("s3_zero", zero_flag, 1'b1);

        // fill the FIFO behind a long-running command
        w0 = wr_cnt; d0 = done_cnt; saw_not_ready = 0; gap_cnt = 0;
        x12_base = rf[12];
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd11, 5'd0, 5'd11, 32'd1, 4'd15));
        @(negedge clk);
        gap_en = 1;
        for (int k = 1; k <= 5; k++)
            send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd12, 5'd0, 5'd12, DW'(k), 4'd1));
        wait_idle(100);
        gap_en = 0;
        check("s4_not_ready_seen", saw_not_ready, 1'b1);
        check("s4_gaps", gap_cnt, 0);
        check("s4_writes", wr_cnt - w0, 26);
        check("s4_done", done_cnt - d0, 6);
        check("s4_x12", rf[12], x12_base + 32'd30);

        // reset in the third issue of an eight-issue command, with more queued
        x13_base = rf[13];
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd13, 5'd0, 5'd13, 32'd1, 4'd7));
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd14, 5'd0, 5'd14, 32'd9, 4'd0));
        send(mk(3'd0, 1'b1, 1'b1, 1'b0, 5'd15, 5'd0, 5'd15, 32'd9, 4'd0));
        @(negedge clk);
        check("s5_pre_rw", RegWrite, 1'b1);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s5_RegWrite", RegWrite, 1'b0);
        check("s5_busy", busy, 1'b0);
        check("s5_ready", cif.cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("s5_no_done", done_cnt - d0, 0);
        check("s5_x13", rf[13], x13_base + 32'd3);

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            drive(mk(CB'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 7) != 0),
                     1'($urandom), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                     AW'($urandom_range(0, 15)), DW'($urandom_range(0, 7)), RB'($urandom_range(0, 3))),
                  1'($urandom_range(0, 2) != 0));
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        cif.cmd_valid = 1'b0;
        rst_n = 1'b1;
        wait_idle(300);
        for (int r = 0; r < 16; r++) check("rf_final", rf[r], mrf[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
